// File: rtl/medidor_pwm_servo_if.sv
// Signal bundle between a servo PWM line and its width meter.
//   pwm          raw PWM line (driven by master)
//   posicao      last valid decoded position code
//   largura      last measured high time in clocks
//   pronto       one-cycle strobe: new measurement completed
//   valido       last measurement matched a nominal width, signal present
//   erro_largura last measurement matched no nominal width
//   sem_sinal    no rising edge for too long, or line stuck high
//   db_estado    meter FSM state (debug)
interface medidor_pwm_servo_if #(
  parameter int unsigned LARGURA_BITS = 20
);
  logic                    pwm;
  logic [2:0]              posicao;
  logic [LARGURA_BITS-1:0] largura;
  logic                    pronto;
  logic                    valido;
  logic                    erro_largura;
  logic                    sem_sinal;
  logic [1:0]              db_estado;

  modport master (
    output pwm,
    input  posicao, largura, pronto, valido, erro_largura, sem_sinal, db_estado
  );

  modport slave (
    input  pwm,
    output posicao, largura, pronto, valido, erro_largura, sem_sinal, db_estado
  );
endinterface

// File: rtl/medidor_pwm_servo.sv
// Servo PWM width meter: measures the high time of a servo PWM line and
// decodes it back to the 3-bit position code (20..160 deg in 20-deg steps),
// flagging malformed widths and missing/stuck signals.
//   clock       system clock
//   reset       asynchronous, active-low reset
//   barramento  slave side of medidor_pwm_servo_if (pwm in, results out)
module medidor_pwm_servo #(
  parameter int unsigned CONF_PERIODO = 1000000,
  parameter int unsigned LARGURA_000  = 55556,
  parameter int unsigned LARGURA_001  = 61111,
  parameter int unsigned LARGURA_010  = 66667,
  parameter int unsigned LARGURA_011  = 72222,
  parameter int unsigned LARGURA_100  = 77778,
  parameter int unsigned LARGURA_101  = 83333,
  parameter int unsigned LARGURA_110  = 88889,
  parameter int unsigned LARGURA_111  = 94444,
  parameter int unsigned TOLERANCIA   = 2000,
  parameter int unsigned TIMEOUT      = 2000000,
  parameter int unsigned LARGURA_BITS = 20
) (
  input  logic                clock,
  input  logic                reset,
  medidor_pwm_servo_if.slave  barramento
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef logic [LARGURA_BITS-1:0] larg_t;
  typedef logic [TW-1:0]           tempo_t;

  localparam larg_t  L_PERIODO = larg_t'(CONF_PERIODO);
  localparam larg_t  L_TOL     = larg_t'(TOLERANCIA);
  localparam tempo_t L_TIMEOUT = tempo_t'(TIMEOUT);

  typedef enum logic [1:0] {
    ESPERA_BAIXO  = 2'b00,
    ESPERA_SUBIDA = 2'b01,
    MEDE_ALTO     = 2'b10,
    DECIDE        = 2'b11
  } estado_t;

  estado_t r_estado, w_prox;

  logic   r_sync1, r_pwm_s, r_pwm_d;
  logic   [1:0] r_armado;
  larg_t  r_cont;
  tempo_t r_tempo;
  logic   [2:0] r_posicao;
  larg_t  r_largura;
  logic   r_pronto, r_valido, r_erro, r_sem;

  logic   w_subida, w_descida, w_estouro, w_achou;
  logic   [2:0] w_codigo;
  tempo_t w_tempo_prox;

  function automatic larg_t nominal(input int unsigned c);
    case (c)
      0:       return larg_t'(LARGURA_000);
      1:       return larg_t'(LARGURA_001);
      2:       return larg_t'(LARGURA_010);
      3:       return larg_t'(LARGURA_011);
      4:       return larg_t'(LARGURA_100);
      5:       return larg_t'(LARGURA_101);
      6:       return larg_t'(LARGURA_110);
      default: return larg_t'(LARGURA_111);
    endcase
  endfunction

  assign w_subida  =  r_pwm_s & ~r_pwm_d;
  assign w_descida = ~r_pwm_s &  r_pwm_d;
  assign w_estouro = (r_cont > L_PERIODO);

  assign w_tempo_prox = w_subida ? '0 :
                        (r_tempo == L_TIMEOUT) ? r_tempo : r_tempo + tempo_t'(1);

  // Synchronizer. r_armado fills with ones two clocks after reset so that
  // ESPERA_BAIXO only trusts pwm_s once the pipeline holds a real sample;
  // otherwise the reset zeros would look like a low level and a pulse already
  // in progress would be measured as a short one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_pwm_s  <= 1'b0;
      r_pwm_d  <= 1'b0;
      r_armado <= '0;
    end else begin
      r_sync1  <= barramento.pwm;
      r_pwm_s  <= r_sync1;
      r_pwm_d  <= r_pwm_s;
      r_armado <= {r_armado[0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= ESPERA_BAIXO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ESPERA_BAIXO:  if (r_armado[1] && !r_pwm_s) w_prox = ESPERA_SUBIDA;
      ESPERA_SUBIDA: if (w_subida) w_prox = MEDE_ALTO;
      MEDE_ALTO: begin
        if (w_estouro)      w_prox = ESPERA_BAIXO;
        else if (w_descida) w_prox = DECIDE;
      end
      DECIDE:        w_prox = ESPERA_SUBIDA;
      default:       w_prox = ESPERA_BAIXO;
    endcase
  end

  // First nominal width (lowest code) within tolerance wins.
  always_comb begin : classifica
    larg_t nom;
    larg_t dif;
    w_achou  = 1'b0;
    w_codigo = '0;
    nom      = '0;
    dif      = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      nom = nominal(i);
      dif = (r_cont >= nom) ? r_cont - nom : nom - r_cont;
      if (!w_achou && dif <= L_TOL) begin
        w_achou  = 1'b1;
        w_codigo = i[2:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cont    <= '0;
      r_tempo   <= '0;
      r_posicao <= '0;
      r_largura <= '0;
      r_pronto  <= 1'b0;
      r_valido  <= 1'b0;
      r_erro    <= 1'b0;
      r_sem     <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      r_tempo  <= w_tempo_prox;

      if (r_estado == ESPERA_SUBIDA && w_subida)
        r_cont <= larg_t'(1);
      else if (r_estado == MEDE_ALTO && r_pwm_s && r_cont != '1)
        r_cont <= r_cont + larg_t'(1);

      if (w_tempo_prox == L_TIMEOUT) begin
        r_sem    <= 1'b1;
        r_valido <= 1'b0;
      end

      if (r_estado == MEDE_ALTO && w_estouro) begin
        r_sem    <= 1'b1;
        r_valido <= 1'b0;
      end

      if (r_estado == DECIDE) begin
        r_largura <= r_cont;
        r_pronto  <= 1'b1;
        if (w_achou) begin
          r_posicao <= w_codigo;
          r_valido  <= 1'b1;
          r_erro    <= 1'b0;
          r_sem     <= 1'b0;
        end else begin
          r_valido  <= 1'b0;
          r_erro    <= 1'b1;
        end
      end
    end
  end

  assign barramento.posicao      = r_posicao;
  assign barramento.largura      = r_largura;
  assign barramento.pronto       = r_pronto;
  assign barramento.valido       = r_valido;
  assign barramento.erro_largura = r_erro;
  assign barramento.sem_sinal    = r_sem;
  assign barramento.db_estado    = r_estado;

endmodule

// File: tb/tb_medidor_pwm_servo.sv
// Directed bench for medidor_pwm_servo with time constants scaled down:
// period 400, nominal widths 100..240 step 20, tolerance 4, timeout 800.
module tb_medidor_pwm_servo;

  localparam int unsigned PER = 400;
  localparam int unsigned TOL = 4;
  localparam int unsigned TMO = 800;
  localparam int unsigned LB  = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pronto = 0;

  medidor_pwm_servo_if #(.LARGURA_BITS(LB)) bus ();

  medidor_pwm_servo #(
    .CONF_PERIODO (PER),
    .LARGURA_000  (100),
    .LARGURA_001  (120),
    .LARGURA_010  (140),
    .LARGURA_011  (160),
    .LARGURA_100  (180),
    .LARGURA_101  (200),
    .LARGURA_110  (220),
    .LARGURA_111  (240),
    .TOLERANCIA   (TOL),
    .TIMEOUT      (TMO),
    .LARGURA_BITS (LB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .barramento (bus)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (bus.pronto) n_pronto++;

  typedef struct {
    int alto;
    int baixo;
    int pos;
    int val;
    int erro;
    int sem;
  } vetor_t;

  vetor_t tab [15];

  task automatic verificar(input string nome, input int atual, input int esperado);
    n_tests++;
    if (atual != esperado) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
    end
  endtask

  task automatic verificar_repouso(input string nome);
    verificar({nome, "_posicao"}, int'(bus.posicao), 0);
    verificar({nome, "_largura"}, int'(bus.largura), 0);
    verificar({nome, "_pronto"},  int'(bus.pronto), 0);
    verificar({nome, "_valido"},  int'(bus.valido), 0);
    verificar({nome, "_erro"},    int'(bus.erro_largura), 0);
    verificar({nome, "_sem"},     int'(bus.sem_sinal), 0);
  endtask

  // Drives one pulse (inputs change at negedge) and checks the resulting report.
  task automatic medir(input string nome, input int alto, input int baixo,
                       input int e_pos, input int e_val, input int e_erro, input int e_sem);
    int k;
    bit achou;
    @(negedge clock) bus.pwm = 1'b1;
    repeat (alto) @(negedge clock);
    bus.pwm = 1'b0;
    achou = 1'b0;
    k = 0;
    for (int c = 1; c <= 10 && !achou; c++) begin
      @(negedge clock);
      if (bus.pronto) begin
        achou = 1'b1;
        k = c;
      end
    end
    verificar({nome, "_latencia"}, k, 4);
    verificar({nome, "_largura"},  int'(bus.largura), alto);
    verificar({nome, "_posicao"},  int'(bus.posicao), e_pos);
    verificar({nome, "_valido"},   int'(bus.valido), e_val);
    verificar({nome, "_erro"},     int'(bus.erro_largura), e_erro);
    verificar({nome, "_sem"},      int'(bus.sem_sinal), e_sem);
    @(negedge clock);
    verificar({nome, "_pronto_1ciclo"}, int'(bus.pronto), 0);
    repeat (baixo) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // alto, baixo, posicao, valido, erro_largura, sem_sinal
    tab[0]  = '{140, 260, 2, 1, 0, 0};
    tab[1]  = '{240, 160, 7, 1, 0, 0};
    tab[2]  = '{100, 300, 0, 1, 0, 0};
    tab[3]  = '{124, 276, 1, 1, 0, 0};
    tab[4]  = '{125, 275, 1, 0, 1, 0};
    tab[5]  = '{116, 284, 1, 1, 0, 0};
    tab[6]  = '{115, 285, 1, 0, 1, 0};
    tab[7]  = '{200, 200, 5, 1, 0, 0};
    tab[8]  = '{171, 229, 5, 0, 1, 0};
    tab[9]  = '{176, 224, 4, 1, 0, 0};
    tab[10] = '{400, 300, 4, 0, 1, 0};
    tab[11] = '{ 96, 304, 0, 1, 0, 0};
    tab[12] = '{ 95, 305, 0, 0, 1, 0};
    tab[13] = '{244, 156, 7, 1, 0, 0};
    tab[14] = '{245, 155, 7, 0, 1, 0};

    bus.pwm = 1'b0;
    repeat (3) @(negedge clock);
    verificar_repouso("reset");
    verificar("reset_estado", int'(bus.db_estado), 0);

    // Line stays low: quiet until the timeout count is reached.
    reset = 1'b1;
    repeat (TMO - 1) @(negedge clock);
    verificar_repouso("antes_timeout");
    verificar("antes_timeout_estado", int'(bus.db_estado), 1);
    @(negedge clock);
    verificar("timeout_sem", int'(bus.sem_sinal), 1);
    verificar("timeout_valido", int'(bus.valido), 0);
    repeat (3 * PER - TMO) @(negedge clock);
    verificar("timeout_sem_mantido", int'(bus.sem_sinal), 1);
    verificar("timeout_sem_pronto", n_pronto, 0);

    for (int i = 0; i < 15; i++)
      medir($sformatf("v%0d", i), tab[i].alto, tab[i].baixo,
            tab[i].pos, tab[i].val, tab[i].erro, tab[i].sem);

    // Reset in the middle of a pulse, released while the line is still high.
    @(negedge clock) bus.pwm = 1'b1;
    repeat (50) @(negedge clock);
    reset = 1'b0;
    #1;
    verificar("reset_meio_posicao", int'(bus.posicao), 0);
    verificar("reset_meio_erro", int'(bus.erro_largura), 0);
    verificar("reset_meio_estado", int'(bus.db_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (128) @(negedge clock);
    @(posedge clock) p0 = n_pronto;
    @(negedge clock) bus.pwm = 1'b0;
    repeat (20) @(negedge clock);
    @(posedge clock) verificar("parcial_sem_pronto", n_pronto, p0);
    verificar("parcial_estado", int'(bus.db_estado), 1);
    repeat (200) @(negedge clock);
    medir("pos_reset", 180, 220, 4, 1, 0, 0);

    // Line stuck high beyond the period: flagged, nothing reported.
    @(posedge clock) p0 = n_pronto;
    @(negedge clock) bus.pwm = 1'b1;
    repeat (200) @(negedge clock);
    verificar("preso_medindo", int'(bus.db_estado), 2);
    repeat (250) @(negedge clock);
    verificar("preso_sem", int'(bus.sem_sinal), 1);
    verificar("preso_valido", int'(bus.valido), 0);
    verificar("preso_estado", int'(bus.db_estado), 0);
    @(posedge clock) verificar("preso_sem_pronto", n_pronto, p0);
    @(negedge clock) bus.pwm = 1'b0;
    repeat (100) @(negedge clock);
    medir("pos_preso", 200, 200, 5, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
